axi_mem_responder: RTL

AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

---
 rtl/axi_mem_responder.sv | 240 ++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 slave that terminates reads and writes in an internal 64-bit-wide RAM.
// Define AXI_MEM_DECERR_EN to answer addresses outside the BASE_NIBBLE window with DECERR.
module axi_mem_responder #(
  parameter int         ADDR_W      = 32,
  parameter int         DATA_W      = 64,
  parameter int         ID_W        = 4,
  parameter int         DEPTH_LOG2  = 10,
  parameter logic [3:0] BASE_NIBBLE = 4'h1
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [ID_W-1:0]       s_axi_awid,
  input  logic [ADDR_W-1:0]     s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awlock,
  input  logic [3:0]            s_axi_awcache,
  input  logic [2:0]            s_axi_awprot,
  input  logic [3:0]            s_axi_awqos,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_W-1:0]     s_axi_wdata,
  input  logic [DATA_W/8-1:0]   s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_W-1:0]       s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ID_W-1:0]       s_axi_arid,
  input  logic [ADDR_W-1:0]     s_axi_araddr,
  input  logic [7:0]            s_axi_arlen,
  input  logic [2:0]            s_axi_arsize,
  input  logic [1:0]            s_axi_arburst,
  input  logic                  s_axi_arlock,
  input  logic [3:0]            s_axi_arcache,
  input  logic [2:0]            s_axi_arprot,
  input  logic [3:0]            s_axi_arqos,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [ID_W-1:0]       s_axi_rid,
  output logic [DATA_W-1:0]     s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rlast,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic       {R_IDLE, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;
  logic     ready_q;

  logic [ID_W-1:0]       r_id, w_id;
  logic [DEPTH_LOG2-1:0] r_idx, w_idx, r_idx_next, w_idx_next;
  logic [7:0]            r_len, r_beat, w_len, w_beat;
  logic [1:0]            r_burst, w_burst, r_resp, w_err, b_resp;
  logic [DATA_W-1:0]     r_data;
  logic                  w_mis;
  logic                  aw_dec, ar_dec;
  logic [1:0]            aw_err, ar_err;
  logic                  ar_fire, r_fire, aw_fire, w_fire;
  logic                  r_last_beat, w_last_beat;
  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;

  // Sideband qualifiers and the address bits outside the word index carry no meaning here.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                       s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                       s_axi_awaddr, s_axi_araddr, BASE_NIBBLE};

`ifdef AXI_MEM_DECERR_EN
  assign aw_dec = (s_axi_awaddr[ADDR_W-1 -: 4] != BASE_NIBBLE);
  assign ar_dec = (s_axi_araddr[ADDR_W-1 -: 4] != BASE_NIBBLE);
`else
  assign aw_dec = 1'b0;
  assign ar_dec = 1'b0;
`endif

  function automatic logic [1:0] req_err(input logic dec, input logic [2:0] size,
                                         input logic [1:0] burst);
    logic [1:0] resp;
    resp = RESP_OKAY;
    if (size != 3'b011 || burst[1]) resp = RESP_SLVERR;
    if (dec) resp = RESP_DECERR;
    return resp;
  endfunction

  assign aw_err = req_err(aw_dec, s_axi_awsize, s_axi_awburst);
  assign ar_err = req_err(ar_dec, s_axi_arsize, s_axi_arburst);
  assign ar_idx = s_axi_araddr[DEPTH_LOG2+2:3];
  assign aw_idx = s_axi_awaddr[DEPTH_LOG2+2:3];

  assign ar_fire     = s_axi_arvalid && s_axi_arready;
  assign r_fire      = s_axi_rvalid && s_axi_rready;
  assign aw_fire     = s_axi_awvalid && s_axi_awready;
  assign w_fire      = s_axi_wvalid && s_axi_wready;
  assign r_last_beat = (r_beat == r_len);
  assign w_last_beat = (w_beat == w_len);
  assign r_idx_next  = (r_burst == BURST_INCR) ? r_idx + DEPTH_LOG2'(1) : r_idx;
  assign w_idx_next  = (w_burst == BURST_INCR) ? w_idx + DEPTH_LOG2'(1) : w_idx;

  // Address channels stay closed for the first cycle after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      ready_q <= 1'b0;
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      ready_q <= 1'b1;
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  always_comb begin
    r_next        = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = ready_q;
        if (s_axi_arvalid && ready_q) r_next = R_BURST;
      end
      R_BURST: begin
        s_axi_rvalid = 1'b1;
        if (s_axi_rready && r_last_beat) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next        = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = ready_q;
        if (s_axi_awvalid && ready_q) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = 1'b1;
        if (s_axi_wvalid && w_last_beat) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = 1'b1;
        if (s_axi_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  // Read data is fetched one beat ahead so it is stable for as long as rready stays low.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= '0;
      r_idx   <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_burst <= '0;
      r_resp  <= RESP_OKAY;
      r_data  <= '0;
    end else if (ar_fire) begin
      r_id    <= s_axi_arid;
      r_idx   <= ar_idx;
      r_len   <= s_axi_arlen;
      r_beat  <= '0;
      r_burst <= s_axi_arburst;
      r_resp  <= ar_err;
      r_data  <= (ar_err == RESP_OKAY) ? mem[ar_idx] : '0;
    end else if (r_fire && !r_last_beat) begin
      r_beat  <= r_beat + 8'd1;
      r_idx   <= r_idx_next;
      r_data  <= (r_resp == RESP_OKAY) ? mem[r_idx_next] : '0;
    end
  end

  assign s_axi_rid   = r_id;
  assign s_axi_rdata = r_data;
  assign s_axi_rresp = r_resp;
  assign s_axi_rlast = (r_state == R_BURST) && r_last_beat;

  // Beat count sequences the burst; a wlast that disagrees only taints the response.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= '0;
      w_idx   <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_burst <= '0;
      w_err   <= RESP_OKAY;
      w_mis   <= 1'b0;
      b_resp  <= RESP_OKAY;
    end else if (aw_fire) begin
      w_id    <= s_axi_awid;
      w_idx   <= aw_idx;
      w_len   <= s_axi_awlen;
      w_beat  <= '0;
      w_burst <= s_axi_awburst;
      w_err   <= aw_err;
      w_mis   <= 1'b0;
    end else if (w_fire) begin
      if (w_last_beat) begin
        if (w_err != RESP_OKAY)          b_resp <= w_err;
        else if (w_mis || !s_axi_wlast)  b_resp <= RESP_SLVERR;
        else                             b_resp <= RESP_OKAY;
      end else begin
        w_beat <= w_beat + 8'd1;
        w_idx  <= w_idx_next;
        w_mis  <= w_mis | s_axi_wlast;
      end
    end
  end

  assign s_axi_bid   = w_id;
  assign s_axi_bresp = b_resp;

  always_ff @(posedge aclk) begin
    if (w_fire && (w_err == RESP_OKAY)) begin
      for (int i = 0; i < DATA_W/8; i++) begin
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
  end

endmodule
